irq_source_ctrl: RTL and testbench
==================================

Name: irq_source_ctrl

Overview:
- Source-side interrupt and reset generator for the 65C02 core; the driving end of the core's RESB/NMIB/IRQB inputs.
- Synchronizes an external reset button and an external NMI line, and stretches reset to the CPU's minimum pulse width.
- Generates fixed-width NMI pulses.
- Aggregates up to 8 peripheral IRQ requests into a latched, maskable, register-accessible flag set that drives a single active-low IRQB.

Parameters:
- N_IRQ, 8, number of peripheral IRQ inputs (1..8); unused register bits read 0.
- SYNC_STAGES, 2, flip-flop stages on ext_resb_in and ext_nmib_in (>=2).
- RES_STRETCH, 4, cycles cpu_resb is held low after the reset cause deasserts (>=2).
- NMI_PULSE, 2, cycles cpu_nmib is held low per NMI event (>=2).

Ports:
- clk  in  1  system clock.
- resb  in  1  system reset, asynchronous, active-low.
- ext_resb_in  in  1  external reset button, asynchronous, active-low.
- ext_nmib_in  in  1  external NMI line, asynchronous, active-low.
- irq_req  in  N_IRQ  peripheral requests, clk-synchronous, active-high.
- reg_wr  in  1  register write strobe.
- reg_rd  in  1  register read strobe.
- reg_addr  in  2  register select.
- reg_wdata  in  8  write data.
- reg_rdata  out  8  read data, registered.
- cpu_resb  out  1  to core RESB, active-low.
- cpu_nmib  out  1  to core NMIB, active-low.
- cpu_irqb  out  1  to core IRQB, active-low.

Behaviour:
- Clock/reset: one clock, clk. resb is asynchronous and active-low.
- Outputs while resb=0: cpu_resb=0, cpu_nmib=1, cpu_irqb=1, reg_rdata=0. Also IFR=0, IER=0, synchronizers=1, reset FSM in HOLD with counter=RES_STRETCH.
- Reset FSM, states HOLD and RUN:
  - HOLD: cpu_resb=0. While the synchronized ext_resb is 0 or a soft reset is requested, reload the counter. Otherwise decrement. When the counter reaches 1, go to RUN at the next edge.
  - RUN: cpu_resb=1. Synchronized ext_resb=0 or a soft-reset write moves to HOLD at the next edge, with counter reload.
  - After resb rises with ext_resb_in=1, cpu_resb goes high exactly RES_STRETCH cycles later.
- While in HOLD:
  - IFR and IER are cleared.
  - cpu_nmib and cpu_irqb are forced to 1.
  - NMI edges are discarded.
  - Register writes are ignored; reads return normal values.
- NMI:
  - A falling edge of synchronized ext_nmib, or a CTRL bit1 write, in RUN loads the pulse counter with NMI_PULSE.
  - cpu_nmib=0 while the counter is nonzero, then returns to 1.
  - New triggers during an active pulse are ignored, not queued.
  - Latency from the ext_nmib_in falling edge to cpu_nmib low is SYNC_STAGES+1 edges. A held-low line produces one pulse only.
- IRQ flags:
  - IFR[i] sets on a rising edge of irq_req[i], detected with a one-cycle registered compare.
  - IFR[i] clears on a write of 1 to IFR bit i.
  - Set and clear in the same cycle: set wins.
- cpu_irqb:
  - Registered as ~|(IFR & IER), so it follows an IFR/IER change by one cycle.
  - It stays low until software clears or masks every enabled flag. It is level, not pulsed.
- Registers (8-bit):
  - addr 0, IFR: read pending; write W1C.
  - addr 1, IER: read/write.
  - addr 2, CTRL: write bit0=1 requests a soft reset, bit1=1 triggers an NMI; other bits ignored. Read: {~cpu_irqb, ~cpu_nmib, 6'b0}.
  - addr 3, RAW: read-only synchronous irq_req; writes ignored.
- Reads: reg_rdata updates on the edge where reg_rd=1 (1-cycle latency) and holds its value otherwise.
- Simultaneous reg_rd and reg_wr to the same address: the read returns the pre-write value.
- Priority follows the core convention, reset > NMI > IRQ: while cpu_resb=0, the other two outputs are 1. NMI and IRQ may be low together.

Decomposition:
- Shared package irq_pkg:
  - reg address constants: ADDR_IFR=0, ADDR_IER=1, ADDR_CTRL=2, ADDR_RAW=3.
  - CTRL bit constants: CTRL_SOFT_RES=0, CTRL_NMI=1.
  - typedef enum logic {RST_HOLD, RST_RUN} rst_state_t.
- Sub-module sync_fall_detect (parameter STAGES, reset value 1): a multi-flop synchronizer plus a registered falling-edge pulse. It is instantiated twice, for ext_resb_in (level used) and ext_nmib_in (edge used).

Test Plan:
- Power-up: resb low for 3 cycles, then high, ext inputs high -> cpu_resb low through 4 cycles after release, high on the 4th edge; cpu_nmib=cpu_irqb=1 throughout; IFR=IER=0.
- ext_nmib_in falls and stays low for 10 cycles -> exactly one cpu_nmib low pulse of 2 cycles starting on the 3rd edge; a second fall 1 cycle into the pulse creates no extra pulse.
- IER=0x05; pulse irq_req[2] -> IFR=0x04, cpu_irqb low 1 cycle later. Write IFR=0x04 in the same cycle as a new irq_req[2] rising edge -> IFR stays 0x04, cpu_irqb stays low. Then write IFR=0x04 -> cpu_irqb high next cycle.
- irq_req[1] edge with IER=0x00 -> IFR=0x02, cpu_irqb stays high; then write IER=0x02 -> cpu_irqb low one cycle later; read CTRL -> 0x80.
- In RUN, write CTRL=0x01 -> cpu_resb low next edge for 4 cycles; IFR/IER read 0x00 afterwards; an ext_nmib_in fall during HOLD produces no pulse.
- ext_resb_in low for 6 cycles mid-operation, cpu_nmib pulse active -> cpu_nmib forced 1, cpu_resb low until 4 cycles after synchronized release.

Source files
------------

// File: rtl/irq_source_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Purpose  : Shared register map, CTRL bit positions and reset-FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

  localparam logic [1:0] ADDR_IFR  = 2'd0;
  localparam logic [1:0] ADDR_IER  = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  localparam int CTRL_SOFT_RES = 0;
  localparam int CTRL_NMI      = 1;

  typedef enum logic {
    RST_HOLD = 1'b0,
    RST_RUN  = 1'b1
  } rst_state_t;

endpackage
`default_nettype wire

// File: rtl/irq_source_ctrl_sync_fall_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_fall_detect
// Purpose  : Multi-flop synchronizer (resets to 1) with a falling-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fall_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic fall_pulse
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], async_in};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign sync_out   = r_sync[STAGES-1];
  // One-cycle pulse, high during the cycle the synchronized level first reads 0.
  assign fall_pulse = r_prev & ~r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/irq_source_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_source_ctrl
// Purpose  : Drives 65C02 RESB/NMIB/IRQB: reset stretch, NMI pulses, IRQ flags.
// Revision : 1.0 - initial release
// ============================================================================
module irq_source_ctrl #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RES_STRETCH = 4,
  parameter int NMI_PULSE   = 2
) (
  input  logic             clk,
  input  logic             resb,
  input  logic             ext_resb_in,
  input  logic             ext_nmib_in,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [1:0]       reg_addr,
  input  logic [7:0]       reg_wdata,
  output logic [7:0]       reg_rdata,
  output logic             cpu_resb,
  output logic             cpu_nmib,
  output logic             cpu_irqb
);

  import irq_pkg::*;

  localparam int c_RES_W = $clog2(RES_STRETCH + 1);
  localparam int c_NMI_W = $clog2(NMI_PULSE + 1);

  rst_state_t         r_state;
  logic [c_RES_W-1:0] r_res_cnt;
  logic [c_NMI_W-1:0] r_nmi_cnt;
  logic [c_NMI_W-1:0] w_nmi_cnt_nxt;
  logic               r_nmib;
  logic               r_irqb;
  logic [N_IRQ-1:0]   r_ifr;
  logic [N_IRQ-1:0]   r_ier;
  logic [N_IRQ-1:0]   r_irq_prev;
  logic [N_IRQ-1:0]   w_irq_rise;
  logic [N_IRQ-1:0]   w_ifr_clr;
  logic [7:0]         r_rdata;
  logic [7:0]         w_ifr8;
  logic [7:0]         w_ier8;
  logic [7:0]         w_raw8;
  logic [7:0]         w_rd_mux;

  logic w_ext_resb_sync;
  logic w_unused_resb_fall;
  logic w_unused_nmib_level;
  logic w_nmib_fall;

  sync_fall_detect #(.STAGES(SYNC_STAGES)) u_sync_resb (
    .clk        (clk),
    .rst_n      (resb),
    .async_in   (ext_resb_in),
    .sync_out   (w_ext_resb_sync),
    .fall_pulse (w_unused_resb_fall)
  );

  sync_fall_detect #(.STAGES(SYNC_STAGES)) u_sync_nmib (
    .clk        (clk),
    .rst_n      (resb),
    .async_in   (ext_nmib_in),
    .sync_out   (w_unused_nmib_level),
    .fall_pulse (w_nmib_fall)
  );

  logic w_run;
  logic w_wr_en;
  logic w_ctrl_wr;
  logic w_soft_req;
  logic w_res_cause;
  logic w_to_hold;
  logic w_block;
  logic w_nmi_trig;

  assign w_run       = (r_state == RST_RUN);
  assign w_wr_en     = reg_wr & w_run;
  assign w_ctrl_wr   = w_wr_en & (reg_addr == ADDR_CTRL);
  assign w_soft_req  = w_ctrl_wr & reg_wdata[CTRL_SOFT_RES];
  assign w_res_cause = ~w_ext_resb_sync | w_soft_req;
  assign w_to_hold   = w_run & w_res_cause;
  // NMI/IRQ are suppressed in HOLD and on the very edge that enters it.
  assign w_block     = ~w_run | w_to_hold;
  assign w_nmi_trig  = w_nmib_fall | (w_ctrl_wr & reg_wdata[CTRL_NMI]);

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      r_state   <= RST_HOLD;
      r_res_cnt <= c_RES_W'(RES_STRETCH);
    end else begin
      case (r_state)
        RST_HOLD: begin
          if (w_res_cause) begin
            r_res_cnt <= c_RES_W'(RES_STRETCH);
          end else if (r_res_cnt == c_RES_W'(1)) begin
            r_state <= RST_RUN;
          end else begin
            r_res_cnt <= r_res_cnt - c_RES_W'(1);
          end
        end
        RST_RUN: begin
          if (w_res_cause) begin
            r_state   <= RST_HOLD;
            r_res_cnt <= c_RES_W'(RES_STRETCH);
          end
        end
        default: begin
          r_state   <= RST_HOLD;
          r_res_cnt <= c_RES_W'(RES_STRETCH);
        end
      endcase
    end
  end

  always_comb begin
    w_nmi_cnt_nxt = '0;
    if (w_block) begin
      w_nmi_cnt_nxt = '0;
    end else if (r_nmi_cnt != '0) begin
      w_nmi_cnt_nxt = r_nmi_cnt - c_NMI_W'(1);
    end else if (w_nmi_trig) begin
      w_nmi_cnt_nxt = c_NMI_W'(NMI_PULSE);
    end
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      r_nmi_cnt <= '0;
      r_nmib    <= 1'b1;
    end else begin
      r_nmi_cnt <= w_nmi_cnt_nxt;
      r_nmib    <= (w_nmi_cnt_nxt == '0);
    end
  end

  assign w_irq_rise = irq_req & ~r_irq_prev;
  assign w_ifr_clr  = (w_wr_en && reg_addr == ADDR_IFR) ? reg_wdata[N_IRQ-1:0] : '0;

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      r_irq_prev <= '0;
      r_ifr      <= '0;
      r_ier      <= '0;
      r_irqb     <= 1'b1;
    end else begin
      r_irq_prev <= irq_req;
      if (!w_run) begin
        r_ifr <= '0;
        r_ier <= '0;
      end else begin
        // Rising edges are OR-ed in after the W1C mask, so a set wins a clear.
        r_ifr <= (r_ifr & ~w_ifr_clr) | w_irq_rise;
        if (w_wr_en && reg_addr == ADDR_IER) begin
          r_ier <= reg_wdata[N_IRQ-1:0];
        end
      end
      r_irqb <= w_block ? 1'b1 : ~|(r_ifr & r_ier);
    end
  end

  always_comb begin
    w_ifr8 = '0;
    w_ier8 = '0;
    w_raw8 = '0;
    w_ifr8[N_IRQ-1:0] = r_ifr;
    w_ier8[N_IRQ-1:0] = r_ier;
    w_raw8[N_IRQ-1:0] = irq_req;
  end

  always_comb begin
    w_rd_mux = '0;
    case (reg_addr)
      ADDR_IFR:  w_rd_mux = w_ifr8;
      ADDR_IER:  w_rd_mux = w_ier8;
      ADDR_CTRL: w_rd_mux = {~r_irqb, ~r_nmib, 6'b0};
      ADDR_RAW:  w_rd_mux = w_raw8;
      default:   w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      r_rdata <= '0;
    end else if (reg_rd) begin
      r_rdata <= w_rd_mux;
    end
  end

  assign reg_rdata = r_rdata;
  assign cpu_resb  = w_run;
  assign cpu_nmib  = r_nmib;
  assign cpu_irqb  = r_irqb;

endmodule
`default_nettype wire

// File: tb/tb_irq_source_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_source_ctrl
// Purpose  : Self-checking bench for irq_source_ctrl (read scoreboard + tasks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_source_ctrl;

  localparam logic [1:0] A_IFR  = 2'd0;
  localparam logic [1:0] A_IER  = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_RAW  = 2'd3;

  logic       clk = 1'b0;
  logic       resb;
  logic       ext_resb_in;
  logic       ext_nmib_in;
  logic [7:0] irq_req;
  logic       reg_wr;
  logic       reg_rd;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       cpu_resb;
  logic       cpu_nmib;
  logic       cpu_irqb;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  irq_source_ctrl #(
    .N_IRQ(8), .SYNC_STAGES(2), .RES_STRETCH(4), .NMI_PULSE(2)
  ) dut (
    .clk        (clk),
    .resb       (resb),
    .ext_resb_in(ext_resb_in),
    .ext_nmib_in(ext_nmib_in),
    .irq_req    (irq_req),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .cpu_resb   (cpu_resb),
    .cpu_nmib   (cpu_nmib),
    .cpu_irqb   (cpu_irqb)
  );

  // Read-data scoreboard: expectation pushed at issue, checked 1 ns after capture.
  always @(posedge clk) begin
    if (reg_rd) begin
      #1;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rdata_unexpected: got %02h, no read was expected", reg_rdata);
      end else if (reg_rdata !== exp_q[0]) begin
        n_fail++;
        $display("FAIL rdata: got %02h, expected %02h", reg_rdata, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e);
    reg_rd = 1'b1; reg_addr = a;
    exp_q.push_back(e);
    tick();
    reg_rd = 1'b0;
  endtask

  task automatic test_reset();
    resb = 1'b0; ext_resb_in = 1'b1; ext_nmib_in = 1'b1; irq_req = '0;
    reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    tick(3);
    n_tests++;
    if ({cpu_resb, cpu_nmib, cpu_irqb, reg_rdata} !== {3'b011, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs: got resb=%b nmib=%b irqb=%b rdata=%02h, expected 0 1 1 00",
               cpu_resb, cpu_nmib, cpu_irqb, reg_rdata);
    end
    resb = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (cpu_resb !== (i == 4) || cpu_nmib !== 1'b1 || cpu_irqb !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_stretch cyc%0d: got resb=%b nmib=%b irqb=%b, expected %b 1 1",
                 i, cpu_resb, cpu_nmib, cpu_irqb, (i == 4));
      end
    end
    rd(A_IFR, 8'h00);
    rd(A_IER, 8'h00);
  endtask

  task automatic test_nmi_ext();
    ext_nmib_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_tests++;
      if (cpu_nmib !== !(i == 3 || i == 4)) begin
        n_fail++;
        $display("FAIL nmi_ext cyc%0d: got nmib=%b, expected %b", i, cpu_nmib, !(i == 3 || i == 4));
      end
    end
    ext_nmib_in = 1'b1;
    tick(3);
  endtask

  task automatic test_nmi_retrigger();
    int lows = 0;
    ext_nmib_in = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) begin
        reg_wr = 1'b1; reg_addr = A_CTRL; reg_wdata = 8'h02;
      end
      tick();
      reg_wr = 1'b0;
      if (!cpu_nmib) lows++;
    end
    n_tests++;
    if (lows != 2) begin
      n_fail++;
      $display("FAIL nmi_retrigger: got %0d low cycles, expected 2", lows);
    end
    ext_nmib_in = 1'b1;
    tick(3);
  endtask

  task automatic test_nmi_soft();
    wr(A_CTRL, 8'h02);
    n_tests++;
    if (cpu_nmib !== 1'b0) begin
      n_fail++;
      $display("FAIL nmi_soft_start: got nmib=%b, expected 0", cpu_nmib);
    end
    rd(A_CTRL, 8'h40);
    tick();
    n_tests++;
    if (cpu_nmib !== 1'b1) begin
      n_fail++;
      $display("FAIL nmi_soft_end: got nmib=%b, expected 1", cpu_nmib);
    end
  endtask

  task automatic test_irq_flags();
    wr(A_IER, 8'h05);
    irq_req = 8'h04;
    tick();
    irq_req = 8'h00;
    n_tests++;
    if (cpu_irqb !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_latency0: got irqb=%b, expected 1", cpu_irqb);
    end
    tick();
    n_tests++;
    if (cpu_irqb !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_assert: got irqb=%b, expected 0", cpu_irqb);
    end
    rd(A_IFR, 8'h04);
    irq_req = 8'h04;
    wr(A_IFR, 8'h04);
    irq_req = 8'h00;
    tick();
    n_tests++;
    if (cpu_irqb !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_set_wins: got irqb=%b, expected 0", cpu_irqb);
    end
    rd(A_IFR, 8'h04);
    rd(A_CTRL, 8'h80);
    wr(A_IFR, 8'h04);
    n_tests++;
    if (cpu_irqb !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear_latency: got irqb=%b, expected 0", cpu_irqb);
    end
    tick();
    n_tests++;
    if (cpu_irqb !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_clear: got irqb=%b, expected 1", cpu_irqb);
    end
    rd(A_IFR, 8'h00);
  endtask

  task automatic test_irq_masked();
    wr(A_IER, 8'h00);
    irq_req = 8'h02;
    tick();
    irq_req = 8'h00;
    tick();
    n_tests++;
    if (cpu_irqb !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_masked: got irqb=%b, expected 1", cpu_irqb);
    end
    rd(A_IFR, 8'h02);
    wr(A_IER, 8'h02);
    tick();
    n_tests++;
    if (cpu_irqb !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_unmask: got irqb=%b, expected 0", cpu_irqb);
    end
    rd(A_CTRL, 8'h80);
  endtask

  task automatic test_regs();
    reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = A_IER; reg_wdata = 8'h33;
    exp_q.push_back(8'h02);
    tick();
    reg_rd = 1'b0; reg_wr = 1'b0;
    rd(A_IER, 8'h33);
    irq_req = 8'hA5;
    rd(A_RAW, 8'hA5);
    irq_req = 8'h00;
    wr(A_RAW, 8'hFF);
    rd(A_RAW, 8'h00);
    rd(A_IFR, 8'hA7);
  endtask

  task automatic test_soft_reset();
    wr(A_CTRL, 8'h01);
    ext_nmib_in = 1'b0;
    n_tests++;
    if (cpu_resb !== 1'b0 || cpu_irqb !== 1'b1) begin
      n_fail++;
      $display("FAIL soft_reset_entry: got resb=%b irqb=%b, expected 0 1", cpu_resb, cpu_irqb);
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_tests++;
      if (cpu_resb !== (i >= 4) || cpu_nmib !== 1'b1) begin
        n_fail++;
        $display("FAIL soft_reset cyc%0d: got resb=%b nmib=%b, expected %b 1",
                 i, cpu_resb, cpu_nmib, (i >= 4));
      end
    end
    ext_nmib_in = 1'b1;
    rd(A_IFR, 8'h00);
    rd(A_IER, 8'h00);
    tick(2);
  endtask

  task automatic test_ext_reset();
    ext_resb_in = 1'b0;
    tick();
    wr(A_CTRL, 8'h02);
    n_tests++;
    if (cpu_nmib !== 1'b0 || cpu_resb !== 1'b1) begin
      n_fail++;
      $display("FAIL ext_reset_pre: got nmib=%b resb=%b, expected 0 1", cpu_nmib, cpu_resb);
    end
    for (int i = 3; i <= 12; i++) begin
      if (i == 7) ext_resb_in = 1'b1;
      tick();
      n_tests++;
      if (cpu_resb !== (i == 12) || cpu_nmib !== 1'b1 || cpu_irqb !== 1'b1) begin
        n_fail++;
        $display("FAIL ext_reset cyc%0d: got resb=%b nmib=%b irqb=%b, expected %b 1 1",
                 i, cpu_resb, cpu_nmib, cpu_irqb, (i == 12));
      end
    end
  endtask

  initial begin
    test_reset();
    test_nmi_ext();
    test_nmi_retrigger();
    test_nmi_soft();
    test_irq_flags();
    test_irq_masked();
    test_regs();
    test_soft_reset();
    test_ext_reset();
    tick(2);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending reads, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
